warp_mask: RTL and testbench

- Per-warp lane predication register for an N-lane SIMD warp.
- Holds the active-lane mask and drives per-lane enables to the lane datapaths.
- Also produces summary status for the issue/control logic: active lane count, any/all flags, lowest active lane index.
- Sits between the warp control/scheduler, which writes the mask, and the lane execution units, which consume lane_enable.

---
 rtl/warp_mask.sv | 93 +++++++++
 tb/tb_warp_mask.sv | 130 +++++++++++++
 2 files changed

// File: rtl/warp_mask.sv
// warp_mask: lane predication register for one SIMD warp.
//
// Holds the active-lane mask, drives per-lane enables, and publishes summary
// status (population count, any/all, lowest active lane) for issue control.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (mask -> all ones)
//   mask_update  in   load strobe; mask_in captured at next rising edge
//   mask_in      in   [NUM_LANES] new mask, bit i = lane i enabled
//   mask_out     out  [NUM_LANES] registered mask
//   lane_enable  out  [NUM_LANES] per-lane enable (same as mask_out)
//   active_count out  [CNT_W] number of set mask bits
//   any_active   out  mask != 0
//   all_active   out  mask == all ones
//   first_lane   out  [IDX_W] index of lowest set bit, 0 when mask == 0

// One lane's predicate bit. Reset wins over load; with no load the bit holds,
// so mask_in (even if X) never reaches the flop unless mask_update is high.
module warp_mask_lane (
  input  logic clk,
  input  logic rst,
  input  logic mask_update,
  input  logic mask_in,
  output logic en
);
  logic en_d, en_q;

  always_comb begin
    en_d = en_q;
    if (rst)              en_d = 1'b1;
    else if (mask_update) en_d = mask_in;
  end

  always_ff @(posedge clk) en_q <= en_d;

  assign en = en_q;
endmodule

module warp_mask #(
  parameter int NUM_LANES = 8,
  localparam int CNT_W = $clog2(NUM_LANES + 1),
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mask_update,
  input  logic [NUM_LANES-1:0] mask_in,
  output logic [NUM_LANES-1:0] mask_out,
  output logic [NUM_LANES-1:0] lane_enable,
  output logic [CNT_W-1:0]     active_count,
  output logic                 any_active,
  output logic                 all_active,
  output logic [IDX_W-1:0]     first_lane
);
  logic [NUM_LANES-1:0] mask_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    warp_mask_lane u_lane (
      .clk         (clk),
      .rst         (rst),
      .mask_update (mask_update),
      .mask_in     (mask_in[l]),
      .en          (mask_q[l])
    );
  end

  assign mask_out    = mask_q;
  assign lane_enable = mask_q;

  // Summary status is a pure function of the register, so it only changes
  // right after a clock edge.
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] first;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      cnt = cnt + CNT_W'(mask_q[i]);
  end

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    first = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask_q[i]) first = IDX_W'(i);
  end

  assign active_count = cnt;
  assign first_lane   = first;
  assign any_active   = |mask_q;
  assign all_active   = &mask_q;
endmodule

// File: tb/tb_warp_mask.sv
module tb_warp_mask;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         mask_update;
  logic [N-1:0] mask_in;
  logic [N-1:0] mask_out;
  logic [N-1:0] lane_enable;
  logic [3:0]   active_count;
  logic         any_active;
  logic         all_active;
  logic [2:0]   first_lane;

  int passed = 0;
  int total  = 0;

  // Reference state: what the mask should be, updated from the rules directly.
  logic [N-1:0] model;

  warp_mask #(.NUM_LANES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .mask_update  (mask_update),
    .mask_in      (mask_in),
    .mask_out     (mask_out),
    .lane_enable  (lane_enable),
    .active_count (active_count),
    .any_active   (any_active),
    .all_active   (all_active),
    .first_lane   (first_lane)
  );

  always #5 clk = ~clk;

  function automatic int lowest_set(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mask_out"},    int'(mask_out),     int'(model));
    chk({tag, ".lane_enable"}, int'(lane_enable),  int'(model));
    chk({tag, ".count"},       int'(active_count), $countones(model));
    chk({tag, ".any"},         int'(any_active),   int'(model != 0));
    chk({tag, ".all"},         int'(all_active),   int'(model == {N{1'b1}}));
    chk({tag, ".first"},       int'(first_lane),   lowest_set(model));
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [N-1:0] v, input string tag);
    mask_in = v;
    mask_update = 1'b1;
    tick();
    mask_update = 1'b0;
    mask_in = N'($urandom);
    model = v;
    tick();
    check_all(tag);
  endtask

  logic [7:0] directed [8] = '{8'b11111110, 8'b00000001, 8'b10000000, 8'b00000000,
                               8'b10101010, 8'b01010101, 8'b00001111, 8'b11110000};

  initial begin
    rst = 1'b1;
    mask_update = 1'b0;
    mask_in = '0;
    model = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all("reset");

    foreach (directed[k]) pulse_load(directed[k], $sformatf("dir%0d", k));

    for (int i = 0; i < N; i++) pulse_load(N'(1) << i, $sformatf("walk%0d", i));

    // Persistence: mask_in wanders while mask_update stays low.
    pulse_load(8'b10101010, "persist_load");
    for (int c = 0; c < 5; c++) begin
      mask_in = N'($urandom);
      tick();
      check_all($sformatf("persist%0d", c));
    end

    // Back-to-back loads: each edge captures that cycle's value.
    mask_update = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mask_in = N'($urandom);
      model = mask_in;
      tick();
      check_all($sformatf("rapid%0d", c));
    end
    mask_update = 1'b0;

    // Random mix of loads and holds.
    for (int c = 0; c < 40; c++) begin
      mask_update = 1'($urandom);
      mask_in = N'($urandom);
      if (mask_update) model = mask_in;
      tick();
      check_all($sformatf("rand%0d", c));
    end

    // Reset beats a simultaneous load of zero.
    mask_update = 1'b1;
    mask_in = 8'h00;
    rst = 1'b1;
    model = '1;
    tick();
    rst = 1'b0;
    mask_update = 1'b0;
    check_all("priority");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
